// File: rtl/pattern_seq.sv
// pattern_seq: multi-channel step-pattern generator with complementary,
// dead-time protected output pins.
// Latency: pins follow a target change one cycle later, plus DEAD_TIME
// cycles when the driven level changes. No backpressure: free-running once
// started.
// Ports:
//   CLK, RESET_N       clock, async active-low reset
//   START, STOP        run control (START sampled in IDLE only, STOP wins)
//   ONESHOT            1 = single pass, 0 = loop (latched with START)
//   PATTERN            channel c step s at bit c*PAT_LEN+s (latched with START)
//   PRESCALE           step length minus one, in CLK cycles (latched with START)
//   PIN_P, PIN_N       true / complementary output per channel
//   BUSY, DONE         running flag, one-cycle one-shot completion pulse
//   LED, USBPU         LED mirrors PIN_P[0]; USB pull-up held off
module pattern_seq #(
  parameter int CHANNELS  = 2,
  parameter int PAT_LEN   = 32,
  parameter int PRESC_W   = 24,
  parameter int DEAD_TIME = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         START,
  input  logic                         STOP,
  input  logic                         ONESHOT,
  input  logic [CHANNELS*PAT_LEN-1:0]  PATTERN,
  input  logic [PRESC_W-1:0]           PRESCALE,
  output logic [CHANNELS-1:0]          PIN_P,
  output logic [CHANNELS-1:0]          PIN_N,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         LED,
  output logic                         USBPU
);

  localparam int STEP_W = $clog2(PAT_LEN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PAT_LEN - 1);
  localparam logic [7:0] DT = 8'(DEAD_TIME);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                        state;
  logic [STEP_W-1:0]             step;
  logic [PRESC_W-1:0]            presc;
  logic [PRESC_W-1:0]            presc_q;
  logic [CHANNELS*PAT_LEN-1:0]   pat_q;
  logic                          oneshot_q;

  // Run control: all run parameters are captured at START so that input
  // changes during a run have no effect.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      step      <= '0;
      presc     <= '0;
      presc_q   <= '0;
      pat_q     <= '0;
      oneshot_q <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && !STOP) begin
            state     <= S_RUN;
            step      <= '0;
            presc     <= '0;
            presc_q   <= PRESCALE;
            pat_q     <= PATTERN;
            oneshot_q <= ONESHOT;
          end
        end
        S_RUN: begin
          if (STOP) begin
            state <= S_IDLE;
          end else if (presc == presc_q) begin
            presc <= '0;
            if (step == LAST_STEP) begin
              step <= '0;
              if (oneshot_q) begin
                state <= S_IDLE;
                DONE  <= 1'b1;
              end
            end else begin
              step <= step + 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY  = (state == S_RUN);
  assign USBPU = 1'b0;
  assign LED   = PIN_P[0];

  wire tgt_on = (state == S_RUN);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    wire [PAT_LEN-1:0] pat_ch  = pat_q[c*PAT_LEN +: PAT_LEN];
    wire               tgt_lvl = pat_ch[step];

    logic       prev_on;
    logic       prev_lvl;
    logic [7:0] dt_cnt;
    logic       p_q;
    logic       n_q;

    // Any change of target (including off -> driven) parks both pins low for
    // DT cycles; a further change restarts the count. Turning off is
    // immediate since it cannot cause shoot-through.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        prev_on  <= 1'b0;
        prev_lvl <= 1'b0;
        dt_cnt   <= '0;
        p_q      <= 1'b0;
        n_q      <= 1'b0;
      end else begin
        prev_on  <= tgt_on;
        prev_lvl <= tgt_lvl;
        if (!tgt_on) begin
          dt_cnt <= '0;
          p_q    <= 1'b0;
          n_q    <= 1'b0;
        end else if (!prev_on || (prev_lvl != tgt_lvl)) begin
          if (DT == 8'd0) begin
            p_q <= tgt_lvl;
            n_q <= ~tgt_lvl;
          end else begin
            dt_cnt <= DT;
            p_q    <= 1'b0;
            n_q    <= 1'b0;
          end
        end else if (dt_cnt > 8'd1) begin
          dt_cnt <= dt_cnt - 8'd1;
          p_q    <= 1'b0;
          n_q    <= 1'b0;
        end else begin
          dt_cnt <= '0;
          p_q    <= tgt_lvl;
          n_q    <= ~tgt_lvl;
        end
      end
    end

    assign PIN_P[c] = p_q;
    assign PIN_N[c] = n_q;
  end

endmodule
